alarm_ctrl: RTL and testbench
=============================

Name: alarm_ctrl

Overview:
Sequencing controller wrapped around the combinational alarm-time comparator. It turns the comparator's level "time equals alarm" match into a single ring event, times how long the buzzer sounds, and handles snooze and stop requests. It sits between the time/alarm registers plus comparator and the buzzer/LED driver, and is clocked by the system clock with one-cycle second and minute tick strobes.

Parameters:
RING_SECS, 60, number of sec_tick pulses a ring lasts before auto-timeout (>=1)
SNOOZE_MIN, 9, number of min_tick pulses in a snooze period before re-ring (>=1)
MAX_SNOOZE, 3, snooze presses honoured per alarm event (used only with SNOOZE_LIMIT_EN)

Ports:
clk  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
alarm_on  in  1  alarm armed (level)
match  in  1  comparator output: minutes, hours and am/pm all equal (level)
sec_tick  in  1  one-cycle strobe, once per second
min_tick  in  1  one-cycle strobe, once per minute
snooze  in  1  one-cycle snooze request (debounced upstream)
stop  in  1  one-cycle stop request (debounced upstream)
buzz  out  1  buzzer drive, high exactly while state==RINGING
snoozing  out  1  high exactly while state==SNOOZE

Behaviour:
- Reset (async): state=IDLE, ring timer=0, snooze timer=0, match_q=1, buzz=0, snoozing=0. match_q resets to 1 so a match already high at reset release does not ring.
- Trigger: match_q <= match every cycle; trigger = match & ~match_q. This gives one trigger per matching minute.
- Outputs are decoded from the state register only. buzz/snoozing change one cycle after the transition condition is sampled.
- Priority within a cycle: ~alarm_on > stop > snooze > timer expiry/tick > trigger.
- IDLE:
  - trigger & alarm_on -> RINGING; load ring timer = RING_SECS.
  - snooze, stop and ticks are ignored.
- RINGING:
  - ~alarm_on or stop -> IDLE.
  - snooze -> SNOOZE; load snooze timer = SNOOZE_MIN.
  - sec_tick decrements the ring timer. A sec_tick with timer==1 -> IDLE (timeout).
  - trigger is ignored.
- SNOOZE:
  - ~alarm_on or stop -> IDLE.
  - min_tick decrements the snooze timer. A min_tick with timer==1 -> RINGING; reload ring timer = RING_SECS.
  - snooze and trigger are ignored.
- Simultaneous events:
  - snooze with the final sec_tick: snooze wins, next state SNOOZE.
  - stop with the final min_tick: stop wins, next state IDLE.
- Timer widths: ring = $clog2(RING_SECS+1), snooze = $clog2(SNOOZE_MIN+1). Timers are unsigned and never wrap below 0; ticks in other states do not change them.
- Reset mid-ring or mid-snooze returns to IDLE immediately. A still-high match does not re-ring, because match_q=1.

Optional Feature:
SNOOZE_LIMIT_EN
- Defined: a snooze counter, width $clog2(MAX_SNOOZE+1) and reset 0, increments on each honoured snooze and clears on entry to IDLE. In RINGING, a snooze with count==MAX_SNOOZE is ignored: ringing continues until stop, alarm_on low or timeout.
- Undefined: the counter is absent and snooze is unlimited.
- Ports are identical in both builds.

Decomposition:
- Package alarm_pkg holds:
  - typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} alarm_state_t
  - default constants RING_SECS_DEF and SNOOZE_MIN_DEF
- One sub-module, alarm_down_cnt: a parameterised loadable down-counter with load, dec, value and is_one outputs. It is instantiated twice, for the ring and snooze timers.

Test Plan (RING_SECS=4, SNOOZE_MIN=2, MAX_SNOOZE=1):
1. alarm_on=1; match rises and stays high 3 cycles -> buzz=1 from the next cycle; exactly one trigger. After 4 sec_ticks buzz=0, state IDLE; match still high causes no re-ring.
2. Ringing; snooze pulse -> snoozing=1, buzz=0. First min_tick: still snoozing. Second min_tick: buzz=1, snoozing=0, ring timer back at 4.
3. Ringing; stop pulse in the same cycle as snooze -> IDLE, both outputs 0. Repeat while snoozing: stop -> IDLE.
4. Ringing; alarm_on drops -> IDLE next cycle. alarm_on=0 with a match edge -> buzz stays 0.
5. Snoozing; assert reset asynchronously mid-cycle -> outputs 0 immediately. Release with match=1 -> no ring until match falls and rises again.
6. With SNOOZE_LIMIT_EN: first snooze honoured; after re-ring a second snooze is ignored and buzz stays 1 until timeout (4 sec_ticks). Without the macro, the second snooze is honoured.

Source files
------------

// File: rtl/alarm_pkg.sv
// alarm_pkg: shared types and default constants for the alarm controller.
//   alarm_state_t  : controller state encoding
//   RING_SECS_DEF  : default ring length in sec_tick pulses
//   SNOOZE_MIN_DEF : default snooze length in min_tick pulses
//   MAX_SNOOZE_DEF : default snooze presses per alarm event (SNOOZE_LIMIT_EN builds)
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RINGING,
    SNOOZE
  } alarm_state_t;

  localparam int RING_SECS_DEF  = 60;
  localparam int SNOOZE_MIN_DEF = 9;
  localparam int MAX_SNOOZE_DEF = 3;

endpackage

// File: rtl/alarm_down_cnt.sv
// alarm_down_cnt: loadable down-counter that saturates at zero.
//   clk, reset : clock, async active-high reset (value -> 0)
//   load       : load load_val (wins over dec)
//   load_val   : value to load
//   dec        : decrement by one; ignored at zero
//   value      : current count
//   is_one     : value == 1, i.e. the next dec expires the timer
module alarm_down_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         is_one
);

  // NOTE: sequential state is updated with <= so every flop samples the
  // pre-edge values of its inputs, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - W'(1);
    end
  end

  assign is_one = (value == W'(1));

endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: turns the alarm comparator's level match into a single ring
// event, times the ring and snooze periods, and handles snooze/stop.
//   clk       : system clock
//   reset     : async active-high reset, clears all state
//   alarm_on  : alarm armed (level)
//   match     : comparator output, time equals alarm (level)
//   sec_tick  : one-cycle strobe per second (ring timer)
//   min_tick  : one-cycle strobe per minute (snooze timer)
//   snooze    : one-cycle snooze request
//   stop      : one-cycle stop request
//   buzz      : high exactly while RINGING
//   snoozing  : high exactly while SNOOZE
// Optional macro SNOOZE_LIMIT_EN: honour at most MAX_SNOOZE snoozes per
// alarm event; without it snooze is unlimited.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SECS  = RING_SECS_DEF,
  parameter int SNOOZE_MIN = SNOOZE_MIN_DEF
`ifdef SNOOZE_LIMIT_EN
  ,
  parameter int MAX_SNOOZE = MAX_SNOOZE_DEF
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic alarm_on,
  input  logic match,
  input  logic sec_tick,
  input  logic min_tick,
  input  logic snooze,
  input  logic stop,
  output logic buzz,
  output logic snoozing
);

  localparam int RW = $clog2(RING_SECS + 1);
  localparam int SW = $clog2(SNOOZE_MIN + 1);

  alarm_state_t state;
  logic         match_q;
  logic         trigger;

  logic          ring_load, ring_dec, ring_one;
  logic [RW-1:0] ring_val;
  logic          snz_load, snz_dec, snz_one;
  logic [SW-1:0] snz_val;
  logic          ring_done, snz_done;
  logic          go_idle, go_ring, go_snooze;
  logic          snooze_ok;

  // Rising edge of the level match: one trigger per matching minute.
  assign trigger = match & ~match_q;

  // A timer sitting at zero is treated as expired so the FSM cannot get
  // stuck if it is ever entered without a load.
  assign ring_done = ring_one | (ring_val == '0);
  assign snz_done  = snz_one  | (snz_val  == '0);

`ifdef SNOOZE_LIMIT_EN
  localparam int CW = $clog2(MAX_SNOOZE + 1);
  logic [CW-1:0] snz_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snz_cnt <= '0;
    end else if (go_idle) begin
      snz_cnt <= '0;
    end else if (snz_load) begin
      snz_cnt <= snz_cnt + CW'(1);
    end
  end

  assign snooze_ok = (snz_cnt != CW'(MAX_SNOOZE));
`else
  assign snooze_ok = 1'b1;
`endif

  // Event decode. Branch order encodes the priority
  // ~alarm_on > stop > snooze > timer tick/expiry > trigger.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    go_idle   = 1'b0;
    go_ring   = 1'b0;
    go_snooze = 1'b0;
    ring_load = 1'b0;
    ring_dec  = 1'b0;
    snz_load  = 1'b0;
    snz_dec   = 1'b0;
    case (state)
      IDLE: begin
        if (alarm_on && trigger) begin
          go_ring   = 1'b1;
          ring_load = 1'b1;
        end
      end
      RINGING: begin
        if (!alarm_on || stop) begin
          go_idle = 1'b1;
        end else if (snooze && snooze_ok) begin
          go_snooze = 1'b1;
          snz_load  = 1'b1;
        end else if (sec_tick) begin
          ring_dec = 1'b1;
          go_idle  = ring_done;
        end
      end
      SNOOZE: begin
        if (!alarm_on || stop) begin
          go_idle = 1'b1;
        end else if (min_tick) begin
          snz_dec = 1'b1;
          if (snz_done) begin
            go_ring   = 1'b1;
            ring_load = 1'b1;
          end
        end
      end
      default: go_idle = 1'b1;
    endcase
  end

  // State register with outputs registered alongside it, so buzz and
  // snoozing always reflect the state register exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      buzz     <= 1'b0;
      snoozing <= 1'b0;
      match_q  <= 1'b1;  // a match already high at release must not ring
    end else begin
      match_q <= match;
      if (go_idle) begin
        state    <= IDLE;
        buzz     <= 1'b0;
        snoozing <= 1'b0;
      end else if (go_ring) begin
        state    <= RINGING;
        buzz     <= 1'b1;
        snoozing <= 1'b0;
      end else if (go_snooze) begin
        state    <= SNOOZE;
        buzz     <= 1'b0;
        snoozing <= 1'b1;
      end
    end
  end

  alarm_down_cnt #(.W(RW)) u_ring_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (ring_load),
    .load_val (RW'(RING_SECS)),
    .dec      (ring_dec),
    .value    (ring_val),
    .is_one   (ring_one)
  );

  alarm_down_cnt #(.W(SW)) u_snz_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (snz_load),
    .load_val (SW'(SNOOZE_MIN)),
    .dec      (snz_dec),
    .value    (snz_val),
    .is_one   (snz_one)
  );

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: directed self-checking bench for alarm_ctrl with
// RING_SECS=4, SNOOZE_MIN=2, MAX_SNOOZE=1 (limit only with SNOOZE_LIMIT_EN).
module tb_alarm_ctrl;

  logic clk = 1'b0;
  logic reset, alarm_on, match, sec_tick, min_tick, snooze, stop;
  logic buzz, snoozing;

  int total = 0;
  int bad   = 0;

  alarm_ctrl #(
    .RING_SECS  (4),
    .SNOOZE_MIN (2)
`ifdef SNOOZE_LIMIT_EN
    ,
    .MAX_SNOOZE (1)
`endif
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .alarm_on (alarm_on),
    .match    (match),
    .sec_tick (sec_tick),
    .min_tick (min_tick),
    .snooze   (snooze),
    .stop     (stop),
    .buzz     (buzz),
    .snoozing (snoozing)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic eb, input logic es);
    check({tag, ".buzz"}, buzz, eb);
    check({tag, ".snoozing"}, snoozing, es);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle pulses; all strobes are cleared after the edge.
  task automatic pulse(input logic s, input logic m, input logic sn, input logic st);
    sec_tick = s; min_tick = m; snooze = sn; stop = st;
    step();
    sec_tick = 0; min_tick = 0; snooze = 0; stop = 0;
  endtask

  // Produce a fresh match edge from IDLE; leaves match low afterwards.
  task automatic ring_start(input string tag);
    match = 0;
    step();
    match = 1;
    step();
    match = 0;
    outs(tag, 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1; alarm_on = 0; match = 0;
    sec_tick = 0; min_tick = 0; snooze = 0; stop = 0;
    #1;
    outs("reset", 1'b0, 1'b0);
    step(); step();
    reset = 0;
    alarm_on = 1;
    step();

    // 1: single trigger, 4-second timeout, held match does not re-ring
    match = 1;
    step();
    outs("t1_ring", 1'b1, 1'b0);
    step(); step();
    outs("t1_hold", 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      pulse(1, 0, 0, 0);
      outs($sformatf("t1_sec%0d", i), 1'b1, 1'b0);
    end
    pulse(1, 0, 0, 0);
    outs("t1_timeout", 1'b0, 1'b0);
    step(); step();
    outs("t1_no_rering", 1'b0, 1'b0);
    pulse(1, 1, 1, 1);
    outs("t1_idle_ignores", 1'b0, 1'b0);

    // 2: snooze, two minutes, re-ring with a full 4-second timer
    ring_start("t2_start");
    pulse(0, 0, 1, 0);
    outs("t2_snooze", 1'b0, 1'b1);
    pulse(1, 0, 0, 0);
    outs("t2_sec_ignored", 1'b0, 1'b1);
    pulse(0, 1, 0, 0);
    outs("t2_min1", 1'b0, 1'b1);
    pulse(0, 1, 0, 0);
    outs("t2_rering", 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      pulse(1, 0, 0, 0);
      outs($sformatf("t2_sec%0d", i), 1'b1, 1'b0);
    end
    pulse(1, 0, 0, 0);
    outs("t2_timeout", 1'b0, 1'b0);

    // 3: stop beats snooze; stop while snoozing; stop beats final min_tick;
    //    snooze beats final sec_tick
    ring_start("t3a_start");
    pulse(0, 0, 1, 1);
    outs("t3a_stop_snooze", 1'b0, 1'b0);
    ring_start("t3b_start");
    pulse(0, 0, 1, 0);
    outs("t3b_snooze", 1'b0, 1'b1);
    pulse(0, 0, 0, 1);
    outs("t3b_stop", 1'b0, 1'b0);
    ring_start("t3c_start");
    pulse(0, 0, 1, 0);
    pulse(0, 1, 0, 0);
    outs("t3c_min1", 1'b0, 1'b1);
    pulse(0, 1, 0, 1);
    outs("t3c_stop_final_min", 1'b0, 1'b0);
    ring_start("t3d_start");
    pulse(1, 0, 0, 0); pulse(1, 0, 0, 0); pulse(1, 0, 0, 0);
    outs("t3d_sec3", 1'b1, 1'b0);
    pulse(1, 0, 1, 0);
    outs("t3d_snooze_final_sec", 1'b0, 1'b1);
    pulse(0, 0, 0, 1);
    outs("t3d_stop", 1'b0, 1'b0);

    // 4: alarm_on low ends a ring and blocks new triggers
    ring_start("t4_start");
    alarm_on = 0;
    step();
    outs("t4_off", 1'b0, 1'b0);
    match = 0; step();
    match = 1; step();
    outs("t4_off_edge", 1'b0, 1'b0);
    step();
    outs("t4_off_edge2", 1'b0, 1'b0);
    alarm_on = 1;
    step();
    outs("t4_rearm_held", 1'b0, 1'b0);

    // 5: async reset mid-snooze; held match after release does not ring
    ring_start("t5_start");
    pulse(0, 0, 1, 0);
    outs("t5_snooze", 1'b0, 1'b1);
    #3;
    reset = 1;
    match = 1;
    #1;
    outs("t5_async", 1'b0, 1'b0);
    step();
    reset = 0;
    step(); step();
    outs("t5_held_match", 1'b0, 1'b0);
    match = 0; step();
    match = 1; step();
    outs("t5_new_edge", 1'b1, 1'b0);
    pulse(0, 0, 0, 1);
    outs("t5_stop", 1'b0, 1'b0);

    // 6: second snooze in one alarm event
    ring_start("t6_start");
    pulse(0, 0, 1, 0);
    pulse(0, 1, 0, 0);
    pulse(0, 1, 0, 0);
    outs("t6_rering", 1'b1, 1'b0);
    pulse(0, 0, 1, 0);
`ifdef SNOOZE_LIMIT_EN
    outs("t6_snooze_limited", 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      pulse(1, 0, 0, 0);
      outs($sformatf("t6_sec%0d", i), 1'b1, 1'b0);
    end
    pulse(1, 0, 0, 0);
    outs("t6_timeout", 1'b0, 1'b0);
    // Count cleared in IDLE: the next event honours a snooze again.
    ring_start("t6_next");
    pulse(0, 0, 1, 0);
    outs("t6_next_snooze", 1'b0, 1'b1);
    pulse(0, 0, 0, 1);
`else
    outs("t6_snooze_again", 1'b0, 1'b1);
    pulse(0, 0, 0, 1);
`endif
    outs("t6_end", 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
